ex_forward: RTL and testbench

EX_FORWARD -- requirements
Module: ex_forward

---
 rtl/ex_forward.sv | 147 ++++++++++++++
 tb/tb_ex_forward.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_forward.sv
// EX-stage operand forwarding and load-use hazard detection.
// Tracks the instructions in the EX and MEM slots and steers Rn/Rm from the regfile, ALU or memory.
module ex_forward #(
    parameter int unsigned      ALUAW  = 4,
    parameter int unsigned      REGAW  = 4,
    parameter logic [ALUAW-1:0] OP_TST = ALUAW'(8),
    parameter logic [ALUAW-1:0] OP_TEQ = ALUAW'(9),
    parameter logic [ALUAW-1:0] OP_CMP = ALUAW'(10),
    parameter logic [ALUAW-1:0] OP_CMN = ALUAW'(11)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [ALUAW-1:0] in_alu_opcode,
    input  logic [REGAW-1:0] in_rd,
    input  logic [REGAW-1:0] in_rn,
    input  logic [REGAW-1:0] in_rm,
    input  logic             in_wr_en,
    input  logic             in_is_load,
    input  logic [31:0]      in_rn_val,
    input  logic [31:0]      in_rm_val,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      op_a,
    output logic [31:0]      op_b,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall
);

    typedef enum logic [1:0] {
        SRC_RF  = 2'd0,
        SRC_EX  = 2'd1,
        SRC_MEM = 2'd2
    } fwd_src_t;

    typedef struct packed {
        logic             valid;
        logic [REGAW-1:0] rd;
        logic             wr;
        logic             is_load;
    } ex_slot_t;

    typedef struct packed {
        logic             valid;
        logic [REGAW-1:0] rd;
        logic             wr;
        logic             is_load;
        logic [31:0]      data;
    } mem_slot_t;

    localparam logic [REGAW-1:0] PC_IDX = REGAW'(15);

    ex_slot_t  ex_q;
    mem_slot_t mem_q;

    logic        flag_only;
    logic        in_wr;
    logic        ex_hit_a;
    logic        ex_hit_b;
    logic        mem_hit_a;
    logic        mem_hit_b;
    logic [31:0] mem_fwd_data;
    fwd_src_t    src_a;
    fwd_src_t    src_b;

    function automatic logic slot_hit(input logic v, input logic w,
                                      input logic [REGAW-1:0] rd,
                                      input logic [REGAW-1:0] idx);
        return v && w && (rd == idx) && (idx != PC_IDX);
    endfunction

    // Compare-style ops only update flags, so they never produce a forwardable result.
    always_comb begin
        flag_only = 1'b0;
        if (in_alu_opcode == OP_TST || in_alu_opcode == OP_TEQ ||
            in_alu_opcode == OP_CMP || in_alu_opcode == OP_CMN)
            flag_only = 1'b1;
        in_wr = in_wr_en && !flag_only;
    end

    always_comb begin
        ex_hit_a     = slot_hit(ex_q.valid, ex_q.wr, ex_q.rd, in_rn);
        ex_hit_b     = slot_hit(ex_q.valid, ex_q.wr, ex_q.rd, in_rm);
        mem_hit_a    = slot_hit(mem_q.valid, mem_q.wr, mem_q.rd, in_rn);
        mem_hit_b    = slot_hit(mem_q.valid, mem_q.wr, mem_q.rd, in_rm);
        mem_fwd_data = mem_q.is_load ? mem_rdata : mem_q.data;
    end

    // A load in EX has no data yet: the operand falls through to MEM/regfile and stall covers it.
    always_comb begin
        src_a = SRC_RF;
        op_a  = in_rn_val;
        if (ex_hit_a && !ex_q.is_load) begin
            src_a = SRC_EX;
            op_a  = alu_result;
        end else if (mem_hit_a) begin
            src_a = SRC_MEM;
            op_a  = mem_fwd_data;
        end

        src_b = SRC_RF;
        op_b  = in_rm_val;
        if (ex_hit_b && !ex_q.is_load) begin
            src_b = SRC_EX;
            op_b  = alu_result;
        end else if (mem_hit_b) begin
            src_b = SRC_MEM;
            op_b  = mem_fwd_data;
        end

        fwd_a_sel = src_a;
        fwd_b_sel = src_b;
    end

    always_comb begin
        stall = in_valid && ex_q.is_load && (ex_hit_a || ex_hit_b);
    end

    // A stalled edge inserts a bubble into EX, so the hazard cannot repeat on the re-presented op.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q.valid    <= 1'b0;
            ex_q.wr       <= 1'b0;
            ex_q.is_load  <= 1'b0;
            mem_q.valid   <= 1'b0;
            mem_q.wr      <= 1'b0;
            mem_q.is_load <= 1'b0;
            mem_q.data    <= '0;
        end else begin
            mem_q.valid   <= ex_q.valid;
            mem_q.rd      <= ex_q.rd;
            mem_q.wr      <= ex_q.wr;
            mem_q.is_load <= ex_q.is_load;
            mem_q.data    <= alu_result;
            if (stall) begin
                ex_q.valid <= 1'b0;
            end else begin
                ex_q.valid   <= in_valid;
                ex_q.rd      <= in_rd;
                ex_q.wr      <= in_wr;
                ex_q.is_load <= in_is_load;
            end
        end
    end

endmodule

// File: tb/tb_ex_forward.sv
// Scenario bench for ex_forward: each step's expected outputs are queued when driven
// and popped for comparison at the following falling edge.
module tb_ex_forward;

    localparam logic [3:0] OPC_SUB = 4'd2;
    localparam logic [3:0] OPC_ADD = 4'd4;
    localparam logic [3:0] OPC_CMP = 4'd10;
    localparam logic [3:0] OPC_ORR = 4'd12;
    localparam logic [3:0] OPC_MOV = 4'd13;

    // mode: 0 = no check, 1 = stall, 2 = stall + selects, 3 = stall + selects + operands
    typedef struct packed {
        logic        rst;
        logic        vld;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic        wr;
        logic        ld;
        logic [31:0] rnv;
        logic [31:0] rmv;
        logic [31:0] alu;
        logic [31:0] mrd;
        logic [1:0]  mode;
        logic        e_stall;
        logic [1:0]  e_sa;
        logic [1:0]  e_sb;
        logic [31:0] e_a;
        logic [31:0] e_b;
    } step_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_alu_opcode;
    logic [3:0]  in_rd;
    logic [3:0]  in_rn;
    logic [3:0]  in_rm;
    logic        in_wr_en;
    logic        in_is_load;
    logic [31:0] in_rn_val;
    logic [31:0] in_rm_val;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic        stall;

    int total = 0;
    int bad   = 0;
    step_t q[$];

    always #5 clk = ~clk;

    ex_forward #(.ALUAW(4), .REGAW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_alu_opcode(in_alu_opcode),
        .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_wr_en(in_wr_en),
        .in_is_load(in_is_load), .in_rn_val(in_rn_val), .in_rm_val(in_rm_val),
        .alu_result(alu_result), .mem_rdata(mem_rdata), .op_a(op_a), .op_b(op_b),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall)
    );

    function automatic step_t mk(input logic r, input logic v, input logic [3:0] op,
                                 input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                                 input logic wr, input logic ld,
                                 input logic [31:0] rnv, input logic [31:0] rmv,
                                 input logic [31:0] alu, input logic [31:0] mrd,
                                 input logic [1:0] mode, input logic stl,
                                 input logic [1:0] sa, input logic [1:0] sb,
                                 input logic [31:0] ea, input logic [31:0] eb);
        step_t s;
        s.rst = r; s.vld = v; s.op = op; s.rd = rd; s.rn = rn; s.rm = rm;
        s.wr = wr; s.ld = ld; s.rnv = rnv; s.rmv = rmv; s.alu = alu; s.mrd = mrd;
        s.mode = mode; s.e_stall = stl; s.e_sa = sa; s.e_sb = sb; s.e_a = ea; s.e_b = eb;
        return s;
    endfunction

    function automatic step_t rstep();
        return mk(1, 0, OPC_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic drive(input step_t s);
        @(posedge clk);
        #1;
        rst = s.rst; in_valid = s.vld; in_alu_opcode = s.op;
        in_rd = s.rd; in_rn = s.rn; in_rm = s.rm;
        in_wr_en = s.wr; in_is_load = s.ld;
        in_rn_val = s.rnv; in_rm_val = s.rmv;
        alu_result = s.alu; mem_rdata = s.mrd;
        q.push_back(s);
    endtask

    task automatic test_reset();
        step_t st[$];
        step_t e;
        st.push_back(rstep());
        st.push_back(mk(0, 1, OPC_ADD, 3, 1, 2, 1, 0, 32'h100, 32'h200, 32'h5, 32'h6, 3, 0, 0, 0, 32'h100, 32'h200));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = q.pop_front();
            if (e.mode >= 1) begin
                total++;
                if (stall !== e.e_stall) begin bad++; $display("FAIL reset[%0d] stall got=%b want=%b", i, stall, e.e_stall); end
            end
            if (e.mode >= 2) begin
                total++;
                if (fwd_a_sel !== e.e_sa) begin bad++; $display("FAIL reset[%0d] fwd_a_sel got=%0d want=%0d", i, fwd_a_sel, e.e_sa); end
                total++;
                if (fwd_b_sel !== e.e_sb) begin bad++; $display("FAIL reset[%0d] fwd_b_sel got=%0d want=%0d", i, fwd_b_sel, e.e_sb); end
            end
            if (e.mode == 3) begin
                total++;
                if (op_a !== e.e_a) begin bad++; $display("FAIL reset[%0d] op_a got=%h want=%h", i, op_a, e.e_a); end
                total++;
                if (op_b !== e.e_b) begin bad++; $display("FAIL reset[%0d] op_b got=%h want=%h", i, op_b, e.e_b); end
            end
        end
    endtask

    task automatic test_ex_forward();
        step_t st[$];
        step_t e;
        st.push_back(rstep());
        st.push_back(mk(0, 1, OPC_ADD, 1, 0, 0, 1, 0, 32'h1, 32'h2, 32'h0, 32'h0, 3, 0, 0, 0, 32'h1, 32'h2));
        st.push_back(mk(0, 1, OPC_SUB, 2, 1, 3, 1, 0, 32'hdead, 32'h3, 32'h11, 32'h0, 3, 0, 1, 0, 32'h11, 32'h3));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = q.pop_front();
            if (e.mode >= 1) begin
                total++;
                if (stall !== e.e_stall) begin bad++; $display("FAIL ex_fwd[%0d] stall got=%b want=%b", i, stall, e.e_stall); end
            end
            if (e.mode >= 2) begin
                total++;
                if (fwd_a_sel !== e.e_sa) begin bad++; $display("FAIL ex_fwd[%0d] fwd_a_sel got=%0d want=%0d", i, fwd_a_sel, e.e_sa); end
                total++;
                if (fwd_b_sel !== e.e_sb) begin bad++; $display("FAIL ex_fwd[%0d] fwd_b_sel got=%0d want=%0d", i, fwd_b_sel, e.e_sb); end
            end
            if (e.mode == 3) begin
                total++;
                if (op_a !== e.e_a) begin bad++; $display("FAIL ex_fwd[%0d] op_a got=%h want=%h", i, op_a, e.e_a); end
                total++;
                if (op_b !== e.e_b) begin bad++; $display("FAIL ex_fwd[%0d] op_b got=%h want=%h", i, op_b, e.e_b); end
            end
        end
    endtask

    task automatic test_mem_forward();
        step_t st[$];
        step_t e;
        st.push_back(rstep());
        st.push_back(mk(0, 1, OPC_ADD, 1, 0, 0, 1, 0, 32'h31, 32'h32, 32'h0, 32'h0, 3, 0, 0, 0, 32'h31, 32'h32));
        st.push_back(mk(0, 0, OPC_ADD, 0, 1, 1, 0, 0, 32'h7, 32'h8, 32'h22, 32'h0, 3, 0, 1, 1, 32'h22, 32'h22));
        st.push_back(mk(0, 1, OPC_ORR, 4, 5, 1, 1, 0, 32'h55, 32'h99, 32'h77, 32'hbad, 3, 0, 0, 2, 32'h55, 32'h22));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = q.pop_front();
            if (e.mode >= 1) begin
                total++;
                if (stall !== e.e_stall) begin bad++; $display("FAIL mem_fwd[%0d] stall got=%b want=%b", i, stall, e.e_stall); end
            end
            if (e.mode >= 2) begin
                total++;
                if (fwd_a_sel !== e.e_sa) begin bad++; $display("FAIL mem_fwd[%0d] fwd_a_sel got=%0d want=%0d", i, fwd_a_sel, e.e_sa); end
                total++;
                if (fwd_b_sel !== e.e_sb) begin bad++; $display("FAIL mem_fwd[%0d] fwd_b_sel got=%0d want=%0d", i, fwd_b_sel, e.e_sb); end
            end
            if (e.mode == 3) begin
                total++;
                if (op_a !== e.e_a) begin bad++; $display("FAIL mem_fwd[%0d] op_a got=%h want=%h", i, op_a, e.e_a); end
                total++;
                if (op_b !== e.e_b) begin bad++; $display("FAIL mem_fwd[%0d] op_b got=%h want=%h", i, op_b, e.e_b); end
            end
        end
    endtask

    task automatic test_load_use();
        step_t st[$];
        step_t e;
        st.push_back(rstep());
        st.push_back(mk(0, 1, OPC_ADD, 6, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 2, 0, 0, 0, 32'h0, 32'h0));
        st.push_back(mk(0, 1, OPC_ADD, 7, 6, 6, 1, 0, 32'h60, 32'h61, 32'h5555, 32'h0, 1, 1, 0, 0, 32'h0, 32'h0));
        st.push_back(mk(0, 1, OPC_ADD, 7, 6, 6, 1, 0, 32'h60, 32'h61, 32'h5555, 32'hcafe, 3, 0, 2, 2, 32'hcafe, 32'hcafe));
        st.push_back(mk(0, 1, OPC_ADD, 8, 6, 7, 1, 0, 32'h66, 32'h67, 32'h4444, 32'hbeef, 3, 0, 0, 1, 32'h66, 32'h4444));
        st.push_back(mk(0, 1, OPC_ADD, 6, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 2, 0, 0, 0, 32'h0, 32'h0));
        st.push_back(mk(0, 0, OPC_ADD, 0, 6, 6, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0, 32'h0));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = q.pop_front();
            if (e.mode >= 1) begin
                total++;
                if (stall !== e.e_stall) begin bad++; $display("FAIL load_use[%0d] stall got=%b want=%b", i, stall, e.e_stall); end
            end
            if (e.mode >= 2) begin
                total++;
                if (fwd_a_sel !== e.e_sa) begin bad++; $display("FAIL load_use[%0d] fwd_a_sel got=%0d want=%0d", i, fwd_a_sel, e.e_sa); end
                total++;
                if (fwd_b_sel !== e.e_sb) begin bad++; $display("FAIL load_use[%0d] fwd_b_sel got=%0d want=%0d", i, fwd_b_sel, e.e_sb); end
            end
            if (e.mode == 3) begin
                total++;
                if (op_a !== e.e_a) begin bad++; $display("FAIL load_use[%0d] op_a got=%h want=%h", i, op_a, e.e_a); end
                total++;
                if (op_b !== e.e_b) begin bad++; $display("FAIL load_use[%0d] op_b got=%h want=%h", i, op_b, e.e_b); end
            end
        end
    endtask

    task automatic test_flag_only();
        step_t st[$];
        step_t e;
        st.push_back(rstep());
        st.push_back(mk(0, 1, OPC_CMP, 1, 1, 2, 1, 0, 32'h5, 32'h2, 32'h0, 32'h0, 2, 0, 0, 0, 32'h0, 32'h0));
        st.push_back(mk(0, 1, OPC_ADD, 3, 1, 1, 1, 0, 32'h5, 32'h5, 32'h999, 32'h0, 3, 0, 0, 0, 32'h5, 32'h5));
        st.push_back(mk(0, 1, OPC_ADD, 4, 1, 0, 1, 0, 32'h5, 32'h0, 32'h888, 32'h777, 3, 0, 0, 0, 32'h5, 32'h0));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = q.pop_front();
            if (e.mode >= 1) begin
                total++;
                if (stall !== e.e_stall) begin bad++; $display("FAIL flag_only[%0d] stall got=%b want=%b", i, stall, e.e_stall); end
            end
            if (e.mode >= 2) begin
                total++;
                if (fwd_a_sel !== e.e_sa) begin bad++; $display("FAIL flag_only[%0d] fwd_a_sel got=%0d want=%0d", i, fwd_a_sel, e.e_sa); end
                total++;
                if (fwd_b_sel !== e.e_sb) begin bad++; $display("FAIL flag_only[%0d] fwd_b_sel got=%0d want=%0d", i, fwd_b_sel, e.e_sb); end
            end
            if (e.mode == 3) begin
                total++;
                if (op_a !== e.e_a) begin bad++; $display("FAIL flag_only[%0d] op_a got=%h want=%h", i, op_a, e.e_a); end
                total++;
                if (op_b !== e.e_b) begin bad++; $display("FAIL flag_only[%0d] op_b got=%h want=%h", i, op_b, e.e_b); end
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        step_t e;
        st.push_back(rstep());
        st.push_back(mk(0, 1, OPC_ADD, 1, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0));
        st.push_back(mk(0, 1, OPC_ADD, 1, 0, 0, 1, 0, 32'h0, 32'h0, 32'ha, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0));
        st.push_back(mk(0, 1, OPC_SUB, 5, 1, 1, 1, 0, 32'h1, 32'h1, 32'hb, 32'hbad, 3, 0, 1, 1, 32'hb, 32'hb));
        st.push_back(mk(0, 1, OPC_ADD, 6, 1, 5, 1, 0, 32'h0, 32'h0, 32'hc, 32'h0, 3, 0, 2, 1, 32'hb, 32'hc));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = q.pop_front();
            if (e.mode >= 1) begin
                total++;
                if (stall !== e.e_stall) begin bad++; $display("FAIL back_to_back[%0d] stall got=%b want=%b", i, stall, e.e_stall); end
            end
            if (e.mode >= 2) begin
                total++;
                if (fwd_a_sel !== e.e_sa) begin bad++; $display("FAIL back_to_back[%0d] fwd_a_sel got=%0d want=%0d", i, fwd_a_sel, e.e_sa); end
                total++;
                if (fwd_b_sel !== e.e_sb) begin bad++; $display("FAIL back_to_back[%0d] fwd_b_sel got=%0d want=%0d", i, fwd_b_sel, e.e_sb); end
            end
            if (e.mode == 3) begin
                total++;
                if (op_a !== e.e_a) begin bad++; $display("FAIL back_to_back[%0d] op_a got=%h want=%h", i, op_a, e.e_a); end
                total++;
                if (op_b !== e.e_b) begin bad++; $display("FAIL back_to_back[%0d] op_b got=%h want=%h", i, op_b, e.e_b); end
            end
        end
    endtask

    task automatic test_r15();
        step_t st[$];
        step_t e;
        st.push_back(rstep());
        st.push_back(mk(0, 1, OPC_MOV, 15, 0, 0, 1, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0));
        st.push_back(mk(0, 1, OPC_ADD, 2, 15, 15, 1, 0, 32'h80, 32'h84, 32'h1000, 32'h0, 3, 0, 0, 0, 32'h80, 32'h84));
        st.push_back(mk(0, 1, OPC_ADD, 3, 15, 2, 1, 0, 32'h80, 32'h0, 32'h2000, 32'h0, 3, 0, 0, 1, 32'h80, 32'h2000));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = q.pop_front();
            if (e.mode >= 1) begin
                total++;
                if (stall !== e.e_stall) begin bad++; $display("FAIL r15[%0d] stall got=%b want=%b", i, stall, e.e_stall); end
            end
            if (e.mode >= 2) begin
                total++;
                if (fwd_a_sel !== e.e_sa) begin bad++; $display("FAIL r15[%0d] fwd_a_sel got=%0d want=%0d", i, fwd_a_sel, e.e_sa); end
                total++;
                if (fwd_b_sel !== e.e_sb) begin bad++; $display("FAIL r15[%0d] fwd_b_sel got=%0d want=%0d", i, fwd_b_sel, e.e_sb); end
            end
            if (e.mode == 3) begin
                total++;
                if (op_a !== e.e_a) begin bad++; $display("FAIL r15[%0d] op_a got=%h want=%h", i, op_a, e.e_a); end
                total++;
                if (op_b !== e.e_b) begin bad++; $display("FAIL r15[%0d] op_b got=%h want=%h", i, op_b, e.e_b); end
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        step_t st[$];
        step_t e;
        st.push_back(rstep());
        st.push_back(mk(0, 1, OPC_ADD, 6, 0, 0, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0));
        st.push_back(mk(1, 1, OPC_ADD, 7, 6, 6, 1, 0, 32'h10, 32'h20, 32'h30, 32'h0, 1, 1, 0, 0, 32'h0, 32'h0));
        st.push_back(mk(0, 1, OPC_ADD, 7, 6, 6, 1, 0, 32'h10, 32'h20, 32'h30, 32'hcafe, 3, 0, 0, 0, 32'h10, 32'h20));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = q.pop_front();
            if (e.mode >= 1) begin
                total++;
                if (stall !== e.e_stall) begin bad++; $display("FAIL rst_stall[%0d] stall got=%b want=%b", i, stall, e.e_stall); end
            end
            if (e.mode >= 2) begin
                total++;
                if (fwd_a_sel !== e.e_sa) begin bad++; $display("FAIL rst_stall[%0d] fwd_a_sel got=%0d want=%0d", i, fwd_a_sel, e.e_sa); end
                total++;
                if (fwd_b_sel !== e.e_sb) begin bad++; $display("FAIL rst_stall[%0d] fwd_b_sel got=%0d want=%0d", i, fwd_b_sel, e.e_sb); end
            end
            if (e.mode == 3) begin
                total++;
                if (op_a !== e.e_a) begin bad++; $display("FAIL rst_stall[%0d] op_a got=%h want=%h", i, op_a, e.e_a); end
                total++;
                if (op_b !== e.e_b) begin bad++; $display("FAIL rst_stall[%0d] op_b got=%h want=%h", i, op_b, e.e_b); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_alu_opcode = '0; in_rd = '0; in_rn = '0; in_rm = '0;
        in_wr_en = 1'b0; in_is_load = 1'b0; in_rn_val = '0; in_rm_val = '0;
        alu_result = '0; mem_rdata = '0;
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_flag_only();
        test_back_to_back();
        test_r15();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
